// File: rtl/gbt_supervisor_pkg.sv
// Shared types and helpers for the multi-link GBT supervisor.
package gbt_supervisor_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle     = 3'd0,
        StWaitMgt  = 3'd1,
        StWaitLink = 3'd2,
        StUp       = 3'd3,
        StFault    = 3'd4
    } link_state_t;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gbt_link_supervisor_if.sv
// Board-status / bank-reset bundle between the supervisor and the GBT banks.
interface gbt_link_supervisor_if
    import gbt_supervisor_pkg::*;
#(
    parameter int unsigned NUM_LINKS = 1,
    parameter int unsigned CNT_W     = 16
) ();
    logic [NUM_LINKS-1:0]       enable_i;
    logic [NUM_LINKS-1:0]       los_i;
    logic [NUM_LINKS-1:0]       clear_fault_i;
    logic [NUM_LINKS-1:0]       mgt_txready_i;
    logic [NUM_LINKS-1:0]       mgt_rxready_i;
    logic [NUM_LINKS-1:0]       link_ready_i;
    logic [NUM_LINKS-1:0]       rx_error_i;
    logic [NUM_LINKS-1:0]       mgt_txreset_o;
    logic [NUM_LINKS-1:0]       mgt_rxreset_o;
    logic [NUM_LINKS-1:0]       gbt_txreset_o;
    logic [NUM_LINKS-1:0]       gbt_rxreset_o;
    logic [NUM_LINKS-1:0]       link_up_o;
    logic [NUM_LINKS-1:0]       fault_o;
    logic                       all_up_o;
    logic [StateW*NUM_LINKS-1:0] state_o;
    logic [CNT_W*NUM_LINKS-1:0] loss_cnt_o;
    logic [CNT_W*NUM_LINKS-1:0] err_cnt_o;

    // master = supervisor side, slave = board/bank side
    modport master (
        input  enable_i, los_i, clear_fault_i, mgt_txready_i, mgt_rxready_i,
               link_ready_i, rx_error_i,
        output mgt_txreset_o, mgt_rxreset_o, gbt_txreset_o, gbt_rxreset_o,
               link_up_o, fault_o, all_up_o, state_o, loss_cnt_o, err_cnt_o
    );

    modport slave (
        output enable_i, los_i, clear_fault_i, mgt_txready_i, mgt_rxready_i,
               link_ready_i, rx_error_i,
        input  mgt_txreset_o, mgt_rxreset_o, gbt_txreset_o, gbt_rxreset_o,
               link_up_o, fault_o, all_up_o, state_o, loss_cnt_o, err_cnt_o
    );

endinterface

// File: rtl/gbt_link_fsm.sv
// Single-link bring-up sequencer: FSM, shared timer, stability/retry counters, loss counter.
// GBT_SUPERVISOR_ERRCNT_EN adds a saturating rx-error counter active while UP.
module gbt_link_fsm
    import gbt_supervisor_pkg::*;
#(
    parameter int unsigned INITIAL_DELAY = 40000000,
    parameter int unsigned READY_TIMEOUT = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             los_i,
    input  logic             clear_fault_i,
    input  logic             mgt_txready_i,
    input  logic             mgt_rxready_i,
    input  logic             link_ready_i,
    input  logic             rx_error_i,
    output logic             mgt_txreset_o,
    output logic             mgt_rxreset_o,
    output logic             gbt_txreset_o,
    output logic             gbt_rxreset_o,
    output logic             link_up_o,
    output logic             fault_o,
    output link_state_t      state_o,
    output logic [CNT_W-1:0] loss_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned TimerW = $clog2(max_u(INITIAL_DELAY, READY_TIMEOUT));
    localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    link_state_t       state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [StabW-1:0]  stab_q, stab_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]  loss_q, loss_d;

    logic              mgt_ready;
    logic [RetryW-1:0] retry_inc;
    link_state_t       fail_state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            timer_q <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign mgt_ready  = mgt_txready_i & mgt_rxready_i;
    assign retry_inc  = retry_q + 1'b1;
    assign fail_state = (retry_inc == RetryW'(MAX_RETRIES)) ? StFault : StIdle;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (!enable_i) begin
            state_d = StIdle;
            timer_d = '0;
            stab_d  = '0;
            retry_d = '0;
        end else if (los_i && state_q != StFault) begin
            state_d = StIdle;
            timer_d = '0;
            stab_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (timer_q == TimerW'(INITIAL_DELAY - 1)) begin
                        state_d = StWaitMgt;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StWaitMgt: begin
                    if (mgt_ready) begin
                        state_d = StWaitLink;
                        timer_d = '0;
                        stab_d  = '0;
                    end else if (timer_q == TimerW'(READY_TIMEOUT - 1)) begin
                        state_d = fail_state;
                        retry_d = retry_inc;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StWaitLink: begin
                    // A ready drop beats a same-cycle success or timeout.
                    if (!mgt_ready || (!(link_ready_i && stab_q == StabW'(STABLE_CYCLES - 1))
                                       && timer_q == TimerW'(READY_TIMEOUT - 1))) begin
                        state_d = fail_state;
                        retry_d = retry_inc;
                        timer_d = '0;
                        stab_d  = '0;
                    end else if (link_ready_i && stab_q == StabW'(STABLE_CYCLES - 1)) begin
                        state_d = StUp;
                        retry_d = '0;
                        timer_d = '0;
                        stab_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        stab_d  = link_ready_i ? stab_q + 1'b1 : '0;
                    end
                end
                StUp: begin
                    if (!(link_ready_i && mgt_ready)) begin
                        state_d = StIdle;
                        loss_d  = (loss_q == CntMax) ? loss_q : loss_q + 1'b1;
                    end
                end
                StFault: begin
                    if (clear_fault_i) begin
                        state_d = StIdle;
                        retry_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mgt_txreset_o = 1'b1;
        mgt_rxreset_o = 1'b1;
        gbt_txreset_o = 1'b1;
        gbt_rxreset_o = 1'b1;
        link_up_o     = 1'b0;
        fault_o       = 1'b0;
        unique case (state_q)
            StWaitMgt: begin
                mgt_txreset_o = 1'b0;
                mgt_rxreset_o = 1'b0;
            end
            StWaitLink: begin
                mgt_txreset_o = 1'b0;
                mgt_rxreset_o = 1'b0;
                gbt_txreset_o = 1'b0;
                gbt_rxreset_o = 1'b0;
            end
            StUp: begin
                mgt_txreset_o = 1'b0;
                mgt_rxreset_o = 1'b0;
                gbt_txreset_o = 1'b0;
                gbt_rxreset_o = 1'b0;
                link_up_o     = 1'b1;
            end
            StFault: fault_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o    = state_q;
    assign loss_cnt_o = loss_q;

`ifdef GBT_SUPERVISOR_ERRCNT_EN
    logic [CNT_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == StUp && rx_error_i && err_q != CntMax) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`else
    logic unused_rx_error;
    assign unused_rx_error = rx_error_i;
    assign err_cnt_o       = '0;
`endif

endmodule

// File: rtl/gbt_link_supervisor.sv
// Multi-link GBT supervisor: one gbt_link_fsm per link plus the all-links-up summary.
// Optional rx-error counters are built when GBT_SUPERVISOR_ERRCNT_EN is defined.
module gbt_link_supervisor
    import gbt_supervisor_pkg::*;
#(
    parameter int unsigned NUM_LINKS     = 1,
    parameter int unsigned INITIAL_DELAY = 40000000,
    parameter int unsigned READY_TIMEOUT = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 8,
    parameter int unsigned CNT_W         = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    gbt_link_supervisor_if.master sup_io
);

    logic [NUM_LINKS-1:0] mgt_txreset, mgt_rxreset, gbt_txreset, gbt_rxreset;
    logic [NUM_LINKS-1:0] link_up, fault;
    link_state_t          link_state [NUM_LINKS];
    logic [CNT_W-1:0]     loss_cnt   [NUM_LINKS];
    logic [CNT_W-1:0]     err_cnt    [NUM_LINKS];

    logic [StateW*NUM_LINKS-1:0] state_flat;
    logic [CNT_W*NUM_LINKS-1:0]  loss_flat, err_flat;

    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_link
        gbt_link_fsm #(
            .INITIAL_DELAY (INITIAL_DELAY),
            .READY_TIMEOUT (READY_TIMEOUT),
            .STABLE_CYCLES (STABLE_CYCLES),
            .MAX_RETRIES   (MAX_RETRIES),
            .CNT_W         (CNT_W)
        ) u_fsm (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .enable_i      (sup_io.enable_i[l]),
            .los_i         (sup_io.los_i[l]),
            .clear_fault_i (sup_io.clear_fault_i[l]),
            .mgt_txready_i (sup_io.mgt_txready_i[l]),
            .mgt_rxready_i (sup_io.mgt_rxready_i[l]),
            .link_ready_i  (sup_io.link_ready_i[l]),
            .rx_error_i    (sup_io.rx_error_i[l]),
            .mgt_txreset_o (mgt_txreset[l]),
            .mgt_rxreset_o (mgt_rxreset[l]),
            .gbt_txreset_o (gbt_txreset[l]),
            .gbt_rxreset_o (gbt_rxreset[l]),
            .link_up_o     (link_up[l]),
            .fault_o       (fault[l]),
            .state_o       (link_state[l]),
            .loss_cnt_o    (loss_cnt[l]),
            .err_cnt_o     (err_cnt[l])
        );
    end

    always_comb begin
        state_flat = '0;
        loss_flat  = '0;
        err_flat   = '0;
        for (int l = 0; l < NUM_LINKS; l++) begin
            state_flat[l*StateW +: StateW] = link_state[l];
            loss_flat[l*CNT_W +: CNT_W]    = loss_cnt[l];
            err_flat[l*CNT_W +: CNT_W]     = err_cnt[l];
        end
    end

    assign sup_io.mgt_txreset_o = mgt_txreset;
    assign sup_io.mgt_rxreset_o = mgt_rxreset;
    assign sup_io.gbt_txreset_o = gbt_txreset;
    assign sup_io.gbt_rxreset_o = gbt_rxreset;
    assign sup_io.link_up_o     = link_up;
    assign sup_io.fault_o       = fault;
    assign sup_io.state_o       = state_flat;
    assign sup_io.loss_cnt_o    = loss_flat;
    assign sup_io.err_cnt_o     = err_flat;

    // Disabled links don't hold all_up low; with none enabled it stays low.
    assign sup_io.all_up_o = (|sup_io.enable_i) & (&(link_up | ~sup_io.enable_i));

endmodule

// File: tb/tb_gbt_link_supervisor.sv
// Randomized scoreboard bench for gbt_link_supervisor against a per-link reference model.
module tb_gbt_link_supervisor;

    localparam int NL   = 2;
    localparam int ID   = 8;
    localparam int RT   = 16;
    localparam int SC   = 4;
    localparam int MR   = 3;
    localparam int CW   = 4;
    localparam int NCYC = 4200;
    localparam int PHASE = 100;

    // spec state codes
    localparam int S_IDLE = 0, S_WMGT = 1, S_WLINK = 2, S_UP = 3, S_FAULT = 4;

    typedef struct packed {
        logic [NL-1:0]      rst_out_mtx;
        logic [NL-1:0]      rst_out_mrx;
        logic [NL-1:0]      rst_out_gtx;
        logic [NL-1:0]      rst_out_grx;
        logic [NL-1:0]      up;
        logic [NL-1:0]      fault;
        logic               all_up;
        logic [3*NL-1:0]    state;
        logic [CW*NL-1:0]   loss;
        logic [CW*NL-1:0]   err;
    } exp_t;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    gbt_link_supervisor_if #(.NUM_LINKS(NL), .CNT_W(CW)) sup_if ();

    gbt_link_supervisor #(
        .NUM_LINKS     (NL),
        .INITIAL_DELAY (ID),
        .READY_TIMEOUT (RT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (CW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .sup_io  (sup_if)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   stop   = 0;

    int m_st[NL], m_tm[NL], m_sb[NL], m_rt[NL], m_loss[NL], m_err[NL];
    int mode[NL];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Reference: each link is an independent sequencer; failure handling bumps the
    // consecutive-failure tally and parks in FAULT once it reaches MR.
    task automatic model_step(input logic rst, input logic [NL-1:0] en, los, cf, tx, rx, lr,
                              input logic [NL-1:0] er);
        exp_t e;
        bit fail;
        bit any_en;
        for (int l = 0; l < NL; l++) begin
            fail = 0;
            if (rst) begin
                m_st[l] = S_IDLE; m_tm[l] = 0; m_sb[l] = 0; m_rt[l] = 0;
                m_loss[l] = 0; m_err[l] = 0;
                continue;
            end
`ifdef GBT_SUPERVISOR_ERRCNT_EN
            if (m_st[l] == S_UP && er[l] && m_err[l] < (1 << CW) - 1) m_err[l]++;
`endif
            if (!en[l]) begin
                m_st[l] = S_IDLE; m_tm[l] = 0; m_sb[l] = 0; m_rt[l] = 0;
            end else if (los[l] && m_st[l] != S_FAULT) begin
                m_st[l] = S_IDLE; m_tm[l] = 0; m_sb[l] = 0;
            end else if (m_st[l] == S_IDLE) begin
                if (m_tm[l] == ID - 1) begin m_st[l] = S_WMGT; m_tm[l] = 0; end
                else m_tm[l]++;
            end else if (m_st[l] == S_WMGT) begin
                if (tx[l] && rx[l]) begin m_st[l] = S_WLINK; m_tm[l] = 0; m_sb[l] = 0; end
                else if (m_tm[l] == RT - 1) fail = 1;
                else m_tm[l]++;
            end else if (m_st[l] == S_WLINK) begin
                if (!(tx[l] && rx[l])) fail = 1;
                else if (lr[l] && m_sb[l] == SC - 1) begin
                    m_st[l] = S_UP; m_rt[l] = 0; m_tm[l] = 0; m_sb[l] = 0;
                end else if (m_tm[l] == RT - 1) fail = 1;
                else begin
                    m_tm[l]++;
                    m_sb[l] = lr[l] ? m_sb[l] + 1 : 0;
                end
            end else if (m_st[l] == S_UP) begin
                if (!(lr[l] && tx[l] && rx[l])) begin
                    m_st[l] = S_IDLE;
                    if (m_loss[l] < (1 << CW) - 1) m_loss[l]++;
                end
            end else begin
                if (cf[l]) begin m_st[l] = S_IDLE; m_rt[l] = 0; end
            end
            if (fail) begin
                m_rt[l]++;
                m_st[l] = (m_rt[l] == MR) ? S_FAULT : S_IDLE;
                m_tm[l] = 0; m_sb[l] = 0;
            end
        end
        e = '0;
        any_en = |en;
        e.all_up = any_en;
        for (int l = 0; l < NL; l++) begin
            e.rst_out_mtx[l] = (m_st[l] == S_IDLE || m_st[l] == S_FAULT);
            e.rst_out_mrx[l] = e.rst_out_mtx[l];
            e.rst_out_gtx[l] = (m_st[l] != S_WLINK && m_st[l] != S_UP);
            e.rst_out_grx[l] = e.rst_out_gtx[l];
            e.up[l]          = (m_st[l] == S_UP);
            e.fault[l]       = (m_st[l] == S_FAULT);
            if (en[l] && m_st[l] != S_UP) e.all_up = 1'b0;
            e.state[l*3 +: 3]   = 3'(m_st[l]);
            e.loss[l*CW +: CW]  = CW'(m_loss[l]);
            e.err[l*CW +: CW]   = CW'(m_err[l]);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a full status word, compared one edge later.
    initial begin
        exp_t e;
        while (!stop) begin
            @(posedge clk);
            #1;
            if (stop) break;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("state",     64'(sup_if.state_o), 64'(e.state));
                chk("mgt_txrst", 64'(sup_if.mgt_txreset_o), 64'(e.rst_out_mtx));
                chk("mgt_rxrst", 64'(sup_if.mgt_rxreset_o), 64'(e.rst_out_mrx));
                chk("gbt_txrst", 64'(sup_if.gbt_txreset_o), 64'(e.rst_out_gtx));
                chk("gbt_rxrst", 64'(sup_if.gbt_rxreset_o), 64'(e.rst_out_grx));
                chk("link_up",   64'(sup_if.link_up_o), 64'(e.up));
                chk("fault",     64'(sup_if.fault_o), 64'(e.fault));
                chk("all_up",    64'(sup_if.all_up_o), 64'(e.all_up));
                chk("loss_cnt",  64'(sup_if.loss_cnt_o), 64'(e.loss));
                chk("err_cnt",   64'(sup_if.err_cnt_o), 64'(e.err));
            end
            cyc++;
        end
    end

    // Driver: inputs change on the falling edge; the model step predicts the next edge.
    initial begin
        logic [NL-1:0] en, los, cf, tx, rx, lr, er;
        int r;
        reset = 1'b1;
        sup_if.enable_i = '0; sup_if.los_i = '0; sup_if.clear_fault_i = '0;
        sup_if.mgt_txready_i = '0; sup_if.mgt_rxready_i = '0;
        sup_if.link_ready_i = '0; sup_if.rx_error_i = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c % PHASE == 0) begin
                for (int l = 0; l < NL; l++) begin
                    r = $urandom_range(0, 9);
                    mode[l] = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
                end
            end
            reset = (c < 3) || (c == 2103);
            for (int l = 0; l < NL; l++) begin
                en[l]  = (mode[l] != 3) && ($urandom_range(0, 299) != 0);
                los[l] = ($urandom_range(0, 149) == 0);
                cf[l]  = ($urandom_range(0, 29) == 0);
                er[l]  = ($urandom_range(0, 3) == 0);
                case (mode[l])
                    0: begin
                        tx[l] = ($urandom_range(0, 399) != 0);
                        rx[l] = ($urandom_range(0, 399) != 0);
                        lr[l] = ($urandom_range(0, 59) != 0);
                    end
                    1: begin
                        tx[l] = ($urandom_range(0, 9) != 0);
                        rx[l] = ($urandom_range(0, 9) != 0);
                        lr[l] = ($urandom_range(0, 3) != 0);
                    end
                    2: begin
                        tx[l] = 1'b1; rx[l] = 1'b0; lr[l] = 1'b0;
                    end
                    default: begin
                        tx[l] = $urandom_range(0, 1); rx[l] = $urandom_range(0, 1);
                        lr[l] = $urandom_range(0, 1);
                    end
                endcase
            end
            sup_if.enable_i      = en;
            sup_if.los_i         = los;
            sup_if.clear_fault_i = cf;
            sup_if.mgt_txready_i = tx;
            sup_if.mgt_rxready_i = rx;
            sup_if.link_ready_i  = lr;
            sup_if.rx_error_i    = er;
            model_step(reset, en, los, cf, tx, rx, lr, er);
        end
        @(posedge clk);
        #3;
        stop = 1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
